even_stream_classifier: RTL

//   Parametrised, pipelined successor to the combinational even/odd checker.

---
 rtl/even_stream_classifier_if.sv | 24 ++
 rtl/even_stream_classifier.sv | 88 ++++++++
 2 files changed

// File: rtl/even_stream_classifier_if.sv
// Stream bundle for the even/odd classifier: input word handshake plus the
// classified output word handshake. The classifier is the slave side; the
// source/consumer environment is the master side.
interface even_stream_classifier_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_even;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_even
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_even
  );
endinterface

// File: rtl/even_stream_classifier.sv
// Pipelined even/odd stream classifier. Accepts WIDTH-bit words over a
// valid/ready handshake, registers each word with its even/odd verdict
// (numeric LSB test or bit-parity test, chosen by mode at acceptance) and
// keeps saturating even/odd tallies with a sticky saturation flag.
module even_stream_classifier #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 clear_cnt,
  even_stream_classifier_if.slave bus,
  output logic [CNT_WIDTH-1:0] even_cnt,
  output logic [CNT_WIDTH-1:0] odd_cnt,
  output logic                 cnt_sat
);

  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic                 out_even_q;
  logic                 in_ready;
  logic                 accept;
  logic                 verdict;
  logic [CNT_WIDTH-1:0] even_base;
  logic [CNT_WIDTH-1:0] odd_base;
  logic                 sat_base;
  logic [CNT_WIDTH-1:0] even_next;
  logic [CNT_WIDTH-1:0] odd_next;
  logic                 sat_next;

  // Reset is OR-ed in so the block advertises ready while held in reset;
  // any word offered then is still discarded by the reset branch below.
  assign in_ready      = reset | ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_even  = out_even_q;

  // Acceptance, classification and next tally values.
  always_comb begin
    accept    = bus.in_valid & in_ready;
    verdict   = mode ? ~(^bus.in_data) : ~bus.in_data[0];
    // Clear is applied first so a same-cycle accept is counted from zero.
    even_base = clear_cnt ? '0 : even_cnt;
    odd_base  = clear_cnt ? '0 : odd_cnt;
    sat_base  = clear_cnt ? 1'b0 : cnt_sat;
    even_next = even_base;
    odd_next  = odd_base;
    if (accept) begin
      if (verdict) begin
        if (even_base != '1) even_next = even_base + CNT_WIDTH'(1);
      end else begin
        if (odd_base != '1) odd_next = odd_base + CNT_WIDTH'(1);
      end
    end
    sat_next = sat_base | (&even_next) | (&odd_next);
  end

  // Output register: load on accept, release on drain, hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_even_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data;
      out_even_q  <= verdict;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating tallies and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      even_cnt <= '0;
      odd_cnt  <= '0;
      cnt_sat  <= 1'b0;
    end else begin
      even_cnt <= even_next;
      odd_cnt  <= odd_next;
      cnt_sat  <= sat_next;
    end
  end

endmodule
